// File: rtl/mod_addsub_seq_pkg.sv
// Shared definitions for the sequenced modular add/subtract block.
//   N_BITS  : operand width used by the top and its adder
//   OP_*    : encodings of the op input
//   state_t : sequencing FSM states
package mod_addsub_seq_pkg;

  localparam int N_BITS = 1027;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RUN1,
    CAP1,
    RUN2,
    CAP2,
    FIN
  } state_t;

endpackage

// File: rtl/mod_addsub_seq_mpadder4.sv
// mpadder4: pipelined carry-select adder/subtractor.
// Operands are presented in one cycle; the result is valid in the next.
// The low half and both candidate upper halves (carry-in 0 and 1) are computed
// before the register; the upper-half select happens after it.
//   clk      : rising-edge clock
//   a, b     : DATA_W-bit operands
//   in_c     : carry-in (add) / borrow-in (subtract)
//   subtract : 0 = a + b + in_c, 1 = a - b - in_c
//   res      : {carry (add) or borrow (subtract), DATA_W-bit sum}
module mpadder4 #(
  parameter int DATA_W = mod_addsub_seq_pkg::N_BITS
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              in_c,
  input  logic              subtract,
  output logic [DATA_W:0]   res
);

  localparam int LO_W = (DATA_W + 1) / 2;
  localparam int HI_W = DATA_W - LO_W;

  logic [DATA_W-1:0] b_eff_p0;
  logic              cin_p0;
  logic [LO_W:0]     lo_p0;
  logic [HI_W:0]     hi0_p0;
  logic [HI_W:0]     hi1_p0;

  logic [LO_W:0]     lo_p1;
  logic [HI_W:0]     hi0_p1;
  logic [HI_W:0]     hi1_p1;
  logic              sub_p1;
  logic [HI_W:0]     hi_sel_p1;

  // Stage p0: two's-complement operand conditioning and segmented sums.
  // Subtraction is a + ~b + 1, so the carry-in is inverted relative to in_c.
  always_comb begin
    b_eff_p0 = subtract ? ~b : b;
    cin_p0   = in_c ^ subtract;
    lo_p0    = {1'b0, a[LO_W-1:0]} + {1'b0, b_eff_p0[LO_W-1:0]}
               + {{LO_W{1'b0}}, cin_p0};
    hi0_p0   = {1'b0, a[DATA_W-1:LO_W]} + {1'b0, b_eff_p0[DATA_W-1:LO_W]};
    hi1_p0   = {1'b0, a[DATA_W-1:LO_W]} + {1'b0, b_eff_p0[DATA_W-1:LO_W]}
               + {{HI_W{1'b0}}, 1'b1};
  end

  // Stage p1: datapath registers; their contents only leave the block
  // through the sequencer's capture states, so no reset is needed.
  always_ff @(posedge clk) begin
    lo_p1  <= lo_p0;
    hi0_p1 <= hi0_p0;
    hi1_p1 <= hi1_p0;
    sub_p1 <= subtract;
  end

  // A carry out of a subtraction means "no borrow", hence the inversion.
  always_comb begin
    hi_sel_p1 = lo_p1[LO_W] ? hi1_p1 : hi0_p1;
    res       = {hi_sel_p1[HI_W] ^ sub_p1, hi_sel_p1[HI_W-1:0], lo_p1[LO_W-1:0]};
  end

endmodule

// File: rtl/mod_addsub_seq.sv
// mod_addsub_seq: computes (A + B) mod M or (A - B) mod M with a fixed
// 5-cycle latency using two passes through one shared pipelined adder.
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset
//   start   : request pulse, accepted only in IDLE
//   op      : 0 = add, 1 = subtract (latched with start)
//   in_a    : operand A (< in_m)
//   in_b    : operand B (< in_m)
//   in_m    : modulus (< 2^(N_BITS-1))
//   busy    : high in every state except IDLE
//   done    : one-cycle pulse in FIN, result valid
//   result  : modular result, held until the next completed operation
module mod_addsub_seq #(
  parameter int N_BITS = mod_addsub_seq_pkg::N_BITS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              op,
  input  logic [N_BITS-1:0] in_a,
  input  logic [N_BITS-1:0] in_b,
  input  logic [N_BITS-1:0] in_m,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  import mod_addsub_seq_pkg::*;

  state_t            state;
  logic [N_BITS-1:0] a_q;
  logic [N_BITS-1:0] b_q;
  logic [N_BITS-1:0] m_q;
  logic              op_q;
  logic [N_BITS-1:0] t_q;
  logic              f1_q;

  logic [N_BITS-1:0] add_a;
  logic [N_BITS-1:0] add_b;
  logic              add_sub;
  logic [N_BITS:0]   add_res;
  logic              keep_t;
  logic [N_BITS-1:0] fin_val;

  // Pass 1 (RUN1) computes a op b. Pass 2 (every other state) corrects by m:
  // an add subtracts m, a subtract adds m back.
  always_comb begin
    add_a   = t_q;
    add_b   = m_q;
    add_sub = (op_q == OP_ADD);
    if (state == RUN1) begin
      add_a   = a_q;
      add_b   = b_q;
      add_sub = op_q;
    end
  end

  mpadder4 #(
    .DATA_W(N_BITS)
  ) u_adder (
    .clk     (clk),
    .a       (add_a),
    .b       (add_b),
    .in_c    (1'b0),
    .subtract(add_sub),
    .res     (add_res)
  );

  // Add: a borrow from t - m means t was already reduced, keep t.
  // Sub: no borrow in pass 1 means a >= b, so t is already the answer.
  always_comb begin
    keep_t  = (op_q == OP_ADD) ? add_res[N_BITS] : ~f1_q;
    fin_val = keep_t ? t_q : add_res[N_BITS-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      op_q   <= 1'b0;
      t_q    <= '0;
      f1_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            op_q  <= op;
            busy  <= 1'b1;
            state <= RUN1;
          end
        end
        RUN1: state <= CAP1;
        CAP1: begin
          t_q   <= add_res[N_BITS-1:0];
          f1_q  <= add_res[N_BITS];
          state <= RUN2;
        end
        RUN2: state <= CAP2;
        CAP2: begin
          result <= fin_val;
          done   <= 1'b1;
          state  <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Self-checking bench for mod_addsub_seq: directed cases plus a randomized
// run compared against a plain-arithmetic modular reference.
module tb_mod_addsub_seq;

  localparam int W = 1027;

  logic          clk;
  logic          resetn;
  logic          start;
  logic          op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [W-1:0]  in_m;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  int n_chk;
  int n_err;
  int done_cnt;

  mod_addsub_seq #(
    .N_BITS(W)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .start (start),
    .op    (op),
    .in_a  (in_a),
    .in_b  (in_b),
    .in_m  (in_m),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got(lo128)=%0h expected(lo128)=%0h", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [W-1:0] rnd_wide();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 33; i++) v = (v << 32) | W'($urandom());
    return v;
  endfunction

  // Reference: (a op b) mod m from plain arithmetic on in-range operands.
  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m, input logic sub);
    logic [W:0] s;
    if (!sub) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end else if (a >= b) begin
      s = {1'b0, a} - {1'b0, b};
    end else begin
      s = {1'b0, a} + {1'b0, m} - {1'b0, b};
    end
    return s[W-1:0];
  endfunction

  // Issue one operation from an IDLE negedge; returns at the following IDLE negedge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m, input logic sub, input string tag);
    logic [W-1:0] exp;
    int lat;
    exp   = ref_mod(a, b, m, sub);
    in_a  = a;
    in_b  = b;
    in_m  = m;
    op    = sub;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in_a  = rnd_wide();
    in_b  = rnd_wide();
    in_m  = rnd_wide();
    op    = 1'($urandom());
    chk({tag, "_busy"}, W'(busy), W'(1));
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"}, W'(lat), W'(5));
    chk({tag, "_res"}, result, exp);
    @(negedge clk);
    chk({tag, "_idle"}, W'(busy), W'(0));
  endtask

  initial begin
    logic [W-1:0] big_m;
    logic [W-1:0] mmask;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rm;
    int cnt0;
    int pulses;
    int mode;

    n_chk    = 0;
    n_err    = 0;
    done_cnt = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    op       = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_m     = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, '0);
    resetn = 1'b1;
    @(negedge clk);

    run_op(W'(7), W'(9), W'(13), 1'b0, "add_7_9");
    run_op(W'(3), W'(9), W'(13), 1'b1, "sub_3_9");
    run_op(W'(5), W'(5), W'(13), 1'b1, "sub_5_5");
    run_op(W'(6), W'(6), W'(13), 1'b0, "add_6_6");

    big_m = '0;
    big_m[W-2] = 1'b1;
    big_m = big_m - W'(1);
    run_op(big_m - W'(1), big_m - W'(1), big_m, 1'b0, "big_add");
    chk("big_add_val", result, big_m - W'(2));
    run_op(W'(0), big_m - W'(1), big_m, 1'b1, "big_sub");
    chk("big_sub_val", result, W'(1));

    // start held high: accepted only in IDLE, once every 6 cycles.
    in_a   = W'(1);
    in_b   = W'(2);
    in_m   = W'(13);
    op     = 1'b0;
    start  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5 || c == 11 || c == 17) begin
        chk($sformatf("burst_done_c%0d", c), W'(done), W'(1));
        chk($sformatf("burst_res_c%0d", c), result, W'(3));
      end
      if (done === 1'b1) begin
        pulses++;
        in_a = W'(1);
        in_b = W'(2);
        in_m = W'(13);
        op   = 1'b0;
      end else if (busy === 1'b1) begin
        in_a = rnd_wide();
        in_b = rnd_wide();
        in_m = rnd_wide();
        op   = 1'($urandom());
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("burst_pulses", W'(pulses), W'(3));
    for (int k = 0; k < 10 && busy === 1'b1; k++) @(negedge clk);
    chk("burst_drain", W'(busy), W'(0));

    // Reset asserted while the operation sits in CAP1.
    in_a  = W'(7);
    in_b  = W'(9);
    in_m  = W'(13);
    op    = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cnt0   = done_cnt;
    resetn = 1'b0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_result", result, '0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_nodone", W'(done_cnt - cnt0), W'(0));
    run_op(W'(7), W'(9), W'(13), 1'b0, "post_rst");

    // Randomized run.
    mmask = '1;
    mmask[W-1] = 1'b0;
    cnt0 = done_cnt;
    for (int i = 0; i < 10000; i++) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 0) rm = W'($urandom_range(2, 64));
      else           rm = rnd_wide() & mmask;
      if (rm < W'(2)) rm = W'(2);
      ra = rnd_wide() % rm;
      rb = rnd_wide() % rm;
      if (mode == 3) begin
        ra = ($urandom_range(0, 1) == 1) ? rm - W'(1) : W'(0);
        rb = ($urandom_range(0, 1) == 1) ? rm - W'(1) : W'(0);
      end
      run_op(ra, rb, rm, 1'($urandom_range(0, 1)), "rand");
    end
    @(negedge clk);
    chk("rand_done_cnt", W'(done_cnt - cnt0), W'(10000));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
